memory_responder: RTL and testbench

Word-addressed main-memory responder for the Mini-SRC datapath. It answers the datapath's MAR/MDR memory requests: it accepts a Read or Write strobe, waits a fixed number of wait states, then commits the write or returns read data on `Mdatain` for the MDR to latch. It pulses `mem_ready` on completion, so the control sequencer can stall its T-state until memory finishes.

---
 rtl/mini_src_pkg.sv | 19 +
 rtl/mem_array.sv | 39 +++
 rtl/memory_responder.sv | 131 +++++++++++++
 tb/tb_memory_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// Shared Mini-SRC memory definitions: responder FSM states, request op codes,
// and default geometry/latency constants also used by the control unit's timeout checks.
package mini_src_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } mem_op_t;

    localparam int unsigned MEM_DEPTH       = 512;
    localparam int unsigned MEM_WAIT_STATES = 2;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port RAM, DEPTH x DATA_WIDTH, with a registered read port.
// Addresses at or beyond DEPTH wrap modulo DEPTH.
module mem_array #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      idx;

    assign idx = IDX_W'(32'(addr) % DEPTH);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // The read register holds the last word read until the next read enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Mini-SRC main-memory responder: latches a Read/Write request, inserts WAIT_STATES
// busy cycles, then completes with a one-cycle mem_ready. Optional macro: MEM_OOR_EN.
module memory_responder
    import mini_src_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = MEM_DEPTH,
    parameter int unsigned WAIT_STATES = MEM_WAIT_STATES
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  mem_ready,
    output logic                  busy,
    output logic                  mem_err
);

    localparam logic       ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    mem_state_t            state;
    mem_op_t               req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic [3:0]            wait_cnt;

    logic                  enter_done;
    logic                  rd_done;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            wait_cnt <= '0;
            req_op   <= OP_RD;
            req_addr <= '0;
            req_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Read || Write) begin
                        req_op   <= Write ? OP_WR : OP_RD;
                        req_addr <= address;
                        req_data <= data_in;
                        wait_cnt <= WAIT_INIT;
                        state    <= ZERO_WAIT ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (wait_cnt == '0) begin
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign mem_ready = (state == DONE);

    // With zero wait states the request goes straight to DONE, so the RAM must be
    // addressed from the live inputs on the accepting edge rather than the latches.
    assign ram_addr   = (state == IDLE) ? address : req_addr;
    assign enter_done = ((state == IDLE) && (Read || Write) && ZERO_WAIT)
                      || ((state == BUSY) && (wait_cnt == '0));
    assign rd_done    = (state == IDLE) ? (Read && !Write && ZERO_WAIT)
                      : ((state == BUSY) && (wait_cnt == '0) && (req_op == OP_RD));

`ifdef MEM_OOR_EN
    logic req_oor;
    logic cur_oor;
    logic rd_ones;
    logic err_q;

    function automatic logic is_oor(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) >= DEPTH);
    endfunction

    assign req_oor = is_oor(req_addr);
    assign cur_oor = (state == IDLE) ? is_oor(address) : req_oor;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            rd_ones <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (rd_done) begin
                rd_ones <= cur_oor;
            end
            err_q <= enter_done && cur_oor;
        end
    end

    assign ram_we  = (state == DONE) && (req_op == OP_WR) && !req_oor;
    assign Mdatain = rd_ones ? '1 : ram_rdata;
    assign mem_err = err_q;
`else
    logic unused_enter_done;

    assign unused_enter_done = enter_done;
    assign ram_we  = (state == DONE) && (req_op == OP_WR);
    assign Mdatain = ram_rdata;
    assign mem_err = 1'b0;
`endif

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem_array (
        .clk   (clock),
        .rst_n (clear),
        .we    (ram_we),
        .re    (rd_done),
        .addr  (ram_addr),
        .wdata (req_data),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a WAIT_STATES=2/DEPTH=256 instance and a
// WAIT_STATES=0/DEPTH=512 instance; expectations follow MEM_OOR_EN when defined.
module tb_memory_responder;

`ifdef MEM_OOR_EN
    localparam bit OOR = 1'b1;
`else
    localparam bit OOR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        clear = 1'b0;

    logic        Read = 1'b0, Write = 1'b0;
    logic [8:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] Mdatain;
    logic        mem_ready, busy, mem_err;

    logic        read0 = 1'b0, write0 = 1'b0;
    logic [8:0]  address0 = '0;
    logic [31:0] data_in0 = '0;
    logic [31:0] mdatain0;
    logic        mem_ready0, busy0, mem_err0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    memory_responder #(
        .ADDR_WIDTH  (9),
        .DATA_WIDTH  (32),
        .DEPTH       (256),
        .WAIT_STATES (2)
    ) u_dut (
        .clock     (clock),
        .clear     (clear),
        .Read      (Read),
        .Write     (Write),
        .address   (address),
        .data_in   (data_in),
        .Mdatain   (Mdatain),
        .mem_ready (mem_ready),
        .busy      (busy),
        .mem_err   (mem_err)
    );

    memory_responder #(
        .ADDR_WIDTH  (9),
        .DATA_WIDTH  (32),
        .DEPTH       (512),
        .WAIT_STATES (0)
    ) u_dut0 (
        .clock     (clock),
        .clear     (clear),
        .Read      (read0),
        .Write     (write0),
        .address   (address0),
        .data_in   (data_in0),
        .Mdatain   (mdatain0),
        .mem_ready (mem_ready0),
        .busy      (busy0),
        .mem_err   (mem_err0)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (mem_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Issues one request on u_dut and returns in its DONE cycle (or after the bound).
    task automatic run_op(input logic rd, input logic wr, input logic [8:0] a,
                          input logic [31:0] d, output int lat);
        Read    = rd;
        Write   = wr;
        address = a;
        data_in = d;
        tick();
        Read  = 1'b0;
        Write = 1'b0;
        wait_ready(lat);
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (Mdatain !== 32'h0) begin errors++; $display("FAIL reset_mdatain got %h want %h", Mdatain, 32'h0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", mem_ready); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", mem_err); end
        clear = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        int lat_w, lat_r;
        Write   = 1'b1;
        address = 9'h055;
        data_in = 32'hDEADBEEF;
        tick();
        Write = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_after_accept got %b want 1", busy); end
        wait_ready(lat_w);
        checks++; if (lat_w !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat_w); end
        tick();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_width got %b want 0", mem_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_done got %b want 0", busy); end
        run_op(1'b1, 1'b0, 9'h055, 32'h0, lat_r);
        checks++; if (lat_r !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", lat_r); end
        checks++; if (Mdatain !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want %h", Mdatain, 32'hDEADBEEF); end
        checks++; if (lat_w + 1 + 1 + lat_r !== 8) begin errors++; $display("FAIL wr_rd_total got %0d want 8", lat_w + 2 + lat_r); end
        tick();
        checks++; if (Mdatain !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_hold got %h want %h", Mdatain, 32'hDEADBEEF); end
    endtask

    task automatic test_simultaneous();
        int lat;
        run_op(1'b1, 1'b1, 9'h020, 32'h12345678, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL simul_latency got %0d want 3", lat); end
        checks++; if (Mdatain !== 32'hDEADBEEF) begin errors++; $display("FAIL simul_mdatain got %h want %h", Mdatain, 32'hDEADBEEF); end
        tick();
        run_op(1'b1, 1'b0, 9'h020, 32'h0, lat);
        checks++; if (Mdatain !== 32'h12345678) begin errors++; $display("FAIL simul_readback got %h want %h", Mdatain, 32'h12345678); end
        tick();
    endtask

    task automatic test_busy_ignore();
        int pulses;
        int lat;
        Write   = 1'b1;
        address = 9'h040;
        data_in = 32'h0BADF00D;
        tick();
        Write = 1'b0;
        tick();
        Read    = 1'b1;
        address = 9'h030;
        tick();
        Read = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_ready === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_ignore_pulses got %0d want 1", pulses); end
        checks++; if (Mdatain !== 32'h12345678) begin errors++; $display("FAIL busy_ignore_mdatain got %h want %h", Mdatain, 32'h12345678); end
        run_op(1'b1, 1'b0, 9'h040, 32'h0, lat);
        checks++; if (Mdatain !== 32'h0BADF00D) begin errors++; $display("FAIL busy_ignore_readback got %h want %h", Mdatain, 32'h0BADF00D); end
        tick();
    endtask

    task automatic test_oor();
        int lat;
        logic [31:0] exp_rd;
        logic [31:0] exp_alias;
        exp_rd    = OOR ? 32'hFFFFFFFF : 32'hCAFEF00D;
        exp_alias = OOR ? 32'h11111111 : 32'hCAFEF00D;
        run_op(1'b0, 1'b1, 9'h0FF, 32'h11111111, lat);
        tick();
        run_op(1'b0, 1'b1, 9'h1FF, 32'hCAFEF00D, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL oor_wr_latency got %0d want 3", lat); end
        checks++; if (mem_err !== OOR) begin errors++; $display("FAIL oor_wr_err got %b want %b", mem_err, OOR); end
        tick();
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL oor_err_width got %b want 0", mem_err); end
        run_op(1'b1, 1'b0, 9'h1FF, 32'h0, lat);
        checks++; if (mem_err !== OOR) begin errors++; $display("FAIL oor_rd_err got %b want %b", mem_err, OOR); end
        checks++; if (Mdatain !== exp_rd) begin errors++; $display("FAIL oor_rd_data got %h want %h", Mdatain, exp_rd); end
        tick();
        run_op(1'b1, 1'b0, 9'h0FF, 32'h0, lat);
        checks++; if (Mdatain !== exp_alias) begin errors++; $display("FAIL oor_alias_word got %h want %h", Mdatain, exp_alias); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL oor_inrange_err got %b want 0", mem_err); end
        tick();
    endtask

    task automatic test_back_to_back_ws0();
        logic [31:0] vals [4];
        vals[0] = 32'h10000001;
        vals[1] = 32'h20000002;
        vals[2] = 32'h30000003;
        vals[3] = 32'h40000004;
        for (int i = 0; i < 4; i++) begin
            write0   = 1'b1;
            address0 = 9'(i + 1);
            data_in0 = vals[i];
            tick();
            write0 = 1'b0;
            tick();
        end
        read0    = 1'b1;
        address0 = 9'h001;
        tick();
        checks++; if (mem_ready0 !== 1'b1) begin errors++; $display("FAIL ws0_ready got %b want 1", mem_ready0); end
        checks++; if (mdatain0 !== vals[0]) begin errors++; $display("FAIL ws0_first_data got %h want %h", mdatain0, vals[0]); end
        for (int i = 1; i < 4; i++) begin
            address0 = 9'(i + 1);
            tick();
            checks++; if (mem_ready0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL ws0_gap_%0d got ready %b busy %b want 0 0", i, mem_ready0, busy0); end
            tick();
            checks++; if (mem_ready0 !== 1'b1) begin errors++; $display("FAIL ws0_ready_%0d got %b want 1", i, mem_ready0); end
            checks++; if (mdatain0 !== vals[i]) begin errors++; $display("FAIL ws0_data_%0d got %h want %h", i, mdatain0, vals[i]); end
        end
        read0 = 1'b0;
        tick();
        checks++; if (mem_err0 !== 1'b0) begin errors++; $display("FAIL ws0_err got %b want 0", mem_err0); end
    endtask

    task automatic test_abort();
        int lat;
        run_op(1'b0, 1'b1, 9'h010, 32'hA5A5A5A5, lat);
        tick();
        Write   = 1'b1;
        address = 9'h010;
        data_in = 32'h5A5A5A5A;
        tick();
        Write = 1'b0;
        tick();
        clear = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL abort_in_reset got busy %b ready %b want 0 0", busy, mem_ready); end
        checks++; if (Mdatain !== 32'h0) begin errors++; $display("FAIL abort_in_reset_mdatain got %h want %h", Mdatain, 32'h0); end
        clear = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL abort_after_release got busy %b ready %b want 0 0", busy, mem_ready); end
        checks++; if (Mdatain !== 32'h0) begin errors++; $display("FAIL abort_after_release_mdatain got %h want %h", Mdatain, 32'h0); end
        run_op(1'b1, 1'b0, 9'h010, 32'h0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL abort_rd_latency got %0d want 3", lat); end
        checks++; if (Mdatain !== 32'hA5A5A5A5) begin errors++; $display("FAIL abort_not_committed got %h want %h", Mdatain, 32'hA5A5A5A5); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_busy_ignore();
        test_oor();
        test_back_to_back_ws0();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
